// File: rtl/ram_port_arbiter_if.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | ram_port_arbiter_if : fetch/data request ports and RAM bus of the arbiter |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
interface ram_port_arbiter_if #(
   parameter int ADDR_BITS = 10
);
   logic                 i_req;
   logic [ADDR_BITS-1:0] i_addr;
   logic                 i_ack;
   logic [31:0]          i_data;

   logic                 d_req;
   logic                 d_wr;
   logic [3:0]           d_wr_mask;
   logic [ADDR_BITS-1:0] d_addr;
   logic [31:0]          d_wdata;
   logic                 d_ack;
   logic [31:0]          d_rdata;

   logic                 ram_wr;
   logic [3:0]           ram_wr_mask;
   logic [ADDR_BITS-1:0] ram_addr;
   logic [31:0]          ram_data_in;
   logic [31:0]          ram_data_out;

   // Requesters and the RAM instance together form the master side.
   modport master (
      output i_req, i_addr, d_req, d_wr, d_wr_mask, d_addr, d_wdata, ram_data_out,
      input  i_ack, i_data, d_ack, d_rdata, ram_wr, ram_wr_mask, ram_addr, ram_data_in
   );

   modport slave (
      input  i_req, i_addr, d_req, d_wr, d_wr_mask, d_addr, d_wdata, ram_data_out,
      output i_ack, i_data, d_ack, d_rdata, ram_wr, ram_wr_mask, ram_addr, ram_data_in
   );
endinterface
`default_nettype wire

// File: rtl/ram_port_arbiter.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | ram_port_arbiter : shares a single-port sync RAM between fetch and data   |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module ram_port_arbiter #(
   parameter int ADDR_BITS = 10
) (
   input  logic               clk,
   input  logic               rst,
   ram_port_arbiter_if.slave  bus,
   output logic               busy
);

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_ISSUE = 2'd1,
      ST_RESP  = 2'd2
   } state_t;

   localparam logic GRANT_FETCH = 1'b0;
   localparam logic GRANT_DATA  = 1'b1;

   state_t               state_q, state_d;
   logic                 grant_q, grant_d;
   logic                 last_grant_q, last_grant_d;
   logic                 wr_q, wr_d;
   logic [3:0]           mask_q, mask_d;
   logic [ADDR_BITS-1:0] addr_q, addr_d;
   logic [31:0]          wdata_q, wdata_d;
   logic                 pick_data;
   logic                 in_issue;
   logic                 in_resp;

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= ST_IDLE;
         grant_q      <= GRANT_FETCH;
         last_grant_q <= GRANT_FETCH;
         wr_q         <= 1'b0;
         mask_q       <= 4'b0000;
         addr_q       <= '0;
         wdata_q      <= 32'd0;
      end else begin
         state_q      <= state_d;
         grant_q      <= grant_d;
         last_grant_q <= last_grant_d;
         wr_q         <= wr_d;
         mask_q       <= mask_d;
         addr_q       <= addr_d;
         wdata_q      <= wdata_d;
      end
   end

   always_comb begin
      state_d      = state_q;
      grant_d      = grant_q;
      last_grant_d = last_grant_q;
      wr_d         = wr_q;
      mask_d       = mask_q;
      addr_d       = addr_q;
      wdata_d      = wdata_q;
      // On a tie the master that was not served last wins.
      pick_data    = bus.d_req && (!bus.i_req || (last_grant_q == GRANT_FETCH));

      case (state_q)
         ST_IDLE: begin
            if (bus.i_req || bus.d_req) begin
               grant_d      = pick_data;
               last_grant_d = pick_data;
               state_d      = ST_ISSUE;
               if (pick_data) begin
                  wr_d    = bus.d_wr;
                  mask_d  = bus.d_wr_mask;
                  addr_d  = bus.d_addr;
                  wdata_d = bus.d_wdata;
               end else begin
                  wr_d   = 1'b0;
                  mask_d = 4'b0000;
                  addr_d = bus.i_addr;
               end
            end
         end
         ST_ISSUE: state_d = ST_RESP;
         ST_RESP:  state_d = ST_IDLE;
         default:  state_d = ST_IDLE;
      endcase
   end

   assign in_issue = (state_q == ST_ISSUE);
   assign in_resp  = (state_q == ST_RESP) && !rst;

   // A write landing on a reset cycle must never reach the RAM.
   assign bus.ram_wr      = in_issue && wr_q && !rst;
   assign bus.ram_wr_mask = (in_issue && wr_q) ? mask_q : 4'b0000;
   assign bus.ram_addr    = addr_q;
   assign bus.ram_data_in = wdata_q;

   assign bus.i_ack   = in_resp && (grant_q == GRANT_FETCH);
   assign bus.d_ack   = in_resp && (grant_q == GRANT_DATA);
   assign bus.i_data  = bus.ram_data_out;
   assign bus.d_rdata = bus.ram_data_out;
   assign busy        = (state_q != ST_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_ram_port_arbiter.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_ram_port_arbiter : scoreboard bench with behavioural RAM and model     |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module tb_ram_port_arbiter;

   logic clk;
   logic rst;
   logic busy;

   ram_port_arbiter_if #(.ADDR_BITS(10)) bus ();

   ram_port_arbiter #(.ADDR_BITS(10)) dut (
      .clk  (clk),
      .rst  (rst),
      .bus  (bus),
      .busy (busy)
   );

   int checks = 0;
   int errors = 0;

   logic [31:0] mem     [0:1023];
   logic [31:0] ref_mem [0:1023];
   logic [31:0] iq [$];
   logic [31:0] dq [$];

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Behavioural single-port RAM with one-cycle registered read.
   always @(posedge clk) begin
      bus.ram_data_out <= mem[bus.ram_addr];
      if (bus.ram_wr) begin
         for (int b = 0; b < 4; b++)
            if (bus.ram_wr_mask[b]) mem[bus.ram_addr][8*b +: 8] = bus.ram_data_in[8*b +: 8];
      end
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Scoreboard monitor: every ack pops the expected word of that master.
   always @(negedge clk) begin
      if (!rst) begin
         if (bus.i_ack) begin
            if (iq.size() == 0) chk("i_ack_unexpected", 32'd1, 32'd0);
            else chk("i_data", bus.i_data, iq.pop_front());
         end
         if (bus.d_ack) begin
            if (dq.size() == 0) chk("d_ack_unexpected", 32'd1, 32'd0);
            else chk("d_rdata", bus.d_rdata, dq.pop_front());
         end
         if (bus.i_ack && bus.d_ack) chk("dual_ack", 32'd1, 32'd0);
         if (!bus.ram_wr) chk("mask_when_no_write", {28'd0, bus.ram_wr_mask}, 32'd0);
      end
   end

   // Issues one access, records the model's expectation, waits for the ack.
   task automatic do_access(input bit is_d, input bit wr, input logic [3:0] mask,
                            input logic [9:0] addr, input logic [31:0] wdata,
                            input bit drop_early, output int lat,
                            output logic [19:0] busy_h, output logic [19:0] wr_h);
      logic [31:0] old;
      logic        ack;
      old = ref_mem[addr];
      if (is_d) begin
         dq.push_back(old);
         if (wr)
            for (int b = 0; b < 4; b++)
               if (mask[b]) ref_mem[addr][8*b +: 8] = wdata[8*b +: 8];
         bus.d_wr      = wr;
         bus.d_wr_mask = mask;
         bus.d_addr    = addr;
         bus.d_wdata   = wdata;
         bus.d_req     = 1'b1;
      end else begin
         iq.push_back(old);
         bus.i_addr = addr;
         bus.i_req  = 1'b1;
      end
      lat    = -1;
      busy_h = '0;
      wr_h   = '0;
      for (int n = 0; n < 20; n++) begin
         @(negedge clk);
         busy_h[n] = busy;
         wr_h[n]   = bus.ram_wr;
         ack = is_d ? bus.d_ack : bus.i_ack;
         if (ack) begin
            lat = n;
            break;
         end
         if (drop_early && n == 0) begin
            @(posedge clk);
            #1;
            if (is_d) bus.d_req = 1'b0;
            else bus.i_req = 1'b0;
         end
      end
      if (lat < 0) chk(is_d ? "d_ack_timeout" : "i_ack_timeout", 32'd0, 32'd1);
      @(posedge clk);
      #1;
      if (is_d) bus.d_req = 1'b0;
      else bus.i_req = 1'b0;
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      int          lat;
      logic [19:0] bh;
      logic [19:0] wh;
      logic        seen;
      logic        exp_d, exp_i;

      for (int a = 0; a < 1024; a++) begin
         mem[a]     = (a * 32'h9E37_79B1) ^ 32'hA5A5_0000;
         ref_mem[a] = mem[a];
      end
      mem[10'h005]     = 32'hDEADBEEF;
      ref_mem[10'h005] = 32'hDEADBEEF;
      mem[10'h010]     = 32'hAABBCCDD;
      ref_mem[10'h010] = 32'hAABBCCDD;

      rst           = 1'b1;
      bus.i_req     = 1'b0;
      bus.i_addr    = '0;
      bus.d_req     = 1'b0;
      bus.d_wr      = 1'b0;
      bus.d_wr_mask = 4'b0000;
      bus.d_addr    = '0;
      bus.d_wdata   = 32'd0;

      // Reset state, with both requests already held high.
      repeat (2) @(posedge clk);
      #1;
      bus.i_addr = 10'h005;
      bus.i_req  = 1'b1;
      bus.d_addr = 10'h030;
      bus.d_wr   = 1'b0;
      bus.d_req  = 1'b1;
      @(negedge clk);
      chk("rst_i_ack", {31'd0, bus.i_ack}, 32'd0);
      chk("rst_d_ack", {31'd0, bus.d_ack}, 32'd0);
      chk("rst_busy", {31'd0, busy}, 32'd0);
      chk("rst_ram_wr", {31'd0, bus.ram_wr}, 32'd0);
      chk("rst_ram_wr_mask", {28'd0, bus.ram_wr_mask}, 32'd0);
      chk("rst_ram_addr", {22'd0, bus.ram_addr}, 32'd0);
      chk("rst_ram_data_in", bus.ram_data_in, 32'd0);
      iq.push_back(ref_mem[10'h005]);
      iq.push_back(ref_mem[10'h005]);
      dq.push_back(ref_mem[10'h030]);
      dq.push_back(ref_mem[10'h030]);
      @(posedge clk);
      #1;
      rst = 1'b0;

      // Continuous tie: D, I, D, I with acks at 2, 5, 8, 11.
      for (int n = 0; n < 12; n++) begin
         @(negedge clk);
         exp_d = (n == 2) || (n == 8);
         exp_i = (n == 5) || (n == 11);
         chk($sformatf("tie_d_ack_c%0d", n), {31'd0, bus.d_ack}, {31'd0, exp_d});
         chk($sformatf("tie_i_ack_c%0d", n), {31'd0, bus.i_ack}, {31'd0, exp_i});
      end
      #1;
      bus.i_req = 1'b0;
      bus.d_req = 1'b0;
      @(posedge clk);
      #1;

      // Fetch-only read.
      do_access(1'b0, 1'b0, 4'b0000, 10'h005, 32'd0, 1'b0, lat, bh, wh);
      chk("fetch_latency", lat, 32'd2);
      chk("fetch_busy_T", {31'd0, bh[0]}, 32'd0);
      chk("fetch_busy_T1_T2", {30'd0, bh[2:1]}, 32'd3);
      chk("fetch_no_ram_wr", {29'd0, wh[2:0]}, 32'd0);

      // Masked write, then read-back.
      do_access(1'b1, 1'b1, 4'b0101, 10'h010, 32'h11223344, 1'b0, lat, bh, wh);
      chk("write_latency", lat, 32'd2);
      chk("write_ram_wr_T1_only", {29'd0, wh[2:0]}, 32'd2);
      chk("write_mem_word", mem[10'h010], 32'hAA22CC44);
      do_access(1'b1, 1'b0, 4'b0000, 10'h010, 32'd0, 1'b0, lat, bh, wh);

      // Zero-mask write still acked, contents unchanged.
      do_access(1'b1, 1'b1, 4'b0000, 10'h020, 32'h12345678, 1'b0, lat, bh, wh);
      chk("mask0_latency", lat, 32'd2);
      do_access(1'b1, 1'b0, 4'b0000, 10'h020, 32'd0, 1'b0, lat, bh, wh);

      // Reset landing on the ISSUE cycle of a write.
      bus.d_wr      = 1'b1;
      bus.d_wr_mask = 4'b1111;
      bus.d_addr    = 10'h040;
      bus.d_wdata   = 32'hFFFF_FFFF;
      bus.d_req     = 1'b1;
      @(negedge clk);
      @(posedge clk);
      #1;
      rst = 1'b1;
      @(negedge clk);
      chk("rst_issue_ram_wr", {31'd0, bus.ram_wr}, 32'd0);
      @(posedge clk);
      #1;
      rst       = 1'b0;
      bus.d_req = 1'b0;
      @(negedge clk);
      chk("rst_issue_idle_after", {31'd0, busy}, 32'd0);
      seen = 1'b0;
      repeat (4) begin
         @(negedge clk);
         seen = seen | bus.d_ack;
      end
      chk("rst_issue_no_ack", {31'd0, seen}, 32'd0);
      chk("rst_issue_mem_kept", mem[10'h040], ref_mem[10'h040]);
      @(posedge clk);
      #1;

      // Request dropped during ISSUE still completes, no second access.
      do_access(1'b1, 1'b0, 4'b0000, 10'h050, 32'd0, 1'b1, lat, bh, wh);
      chk("drop_latency", lat, 32'd2);
      seen = 1'b0;
      repeat (4) begin
         @(negedge clk);
         seen = seen | busy;
      end
      chk("drop_no_second_access", {31'd0, seen}, 32'd0);
      @(posedge clk);
      #1;

      // Randomized concurrent traffic on disjoint address halves.
      fork
         begin
            int          l;
            logic [19:0] b1, w1;
            for (int k = 0; k < 40; k++) begin
               repeat ($urandom_range(0, 3)) @(posedge clk);
               #1;
               do_access(1'b0, 1'b0, 4'b0000, 10'($urandom_range(0, 511)), 32'd0, 1'b0, l, b1, w1);
               chk("rand_fetch_latency_le5", {31'd0, (l >= 0 && l <= 5)}, 32'd1);
            end
         end
         begin
            int          l;
            logic [19:0] b2, w2;
            for (int k = 0; k < 40; k++) begin
               repeat ($urandom_range(0, 3)) @(posedge clk);
               #1;
               do_access(1'b1, 1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)),
                         10'(512 + $urandom_range(0, 511)), $urandom, 1'b0, l, b2, w2);
               chk("rand_data_latency_le5", {31'd0, (l >= 0 && l <= 5)}, 32'd1);
            end
         end
      join

      repeat (4) @(negedge clk);
      chk("iq_drained", iq.size(), 32'd0);
      chk("dq_drained", dq.size(), 32'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/ram_port_arbiter.md
# ram_port_arbiter

Two-master arbiter that shares the single-port synchronous on-chip RAM between the CPU instruction-fetch port (read-only) and the load/store data port (read/write with byte mask). It latches one request at a time, drives the RAM address/write/mask/data lines for one cycle, captures the RAM's one-cycle read latency and returns a one-cycle acknowledge to the granted master. Sits between the core's fetch and memory stages and the RAM instance.

## Interface

- ADDR_BITS, 10, word-address width; must match the RAM's ADDR_BITS.

- clk  in  1  system clock; all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- i_req  in  1  fetch request; held with i_addr stable until i_ack.
- i_addr  in  ADDR_BITS  fetch word address.
- i_ack  out  1  one-cycle pulse; i_data valid in the same cycle.
- i_data  out  32  fetched word.
- d_req  in  1  data request; held with all d_* inputs stable until d_ack.
- d_wr  in  1  1 = write, 0 = read.
- d_wr_mask  in  4  byte enables for a write; bit n covers data[8n+7:8n].
- d_addr  in  ADDR_BITS  data word address.
- d_wdata  in  32  write data.
- d_ack  out  1  one-cycle pulse; d_rdata valid in the same cycle.
- d_rdata  out  32  read data; for a write, the word's contents before the write.
- ram_wr  out  1  RAM write enable.
- ram_wr_mask  out  4  RAM byte enables.
- ram_addr  out  ADDR_BITS  RAM address.
- ram_data_in  out  32  RAM write data.
- ram_data_out  in  32  RAM registered read data (valid one cycle after address).
- busy  out  1  high when state is not IDLE.

## Operation

- States: IDLE -> ISSUE -> RESP -> IDLE. Every access, read or write, takes exactly this path.
- IDLE: if any request is present, pick a grant, latch addr, wr, wr_mask, wdata and grant into internal registers, go to ISSUE. Otherwise stay.
- Fetch grants latch wr=0 and mask=0. Data grants latch d_wr, d_wr_mask and d_wdata.
- Arbitration: if one request is present, grant it. If both are present, grant the master not granted last. The last_grant register updates on every grant and resets to "fetch", so the first tie after reset goes to data.
- ISSUE:
  - ram_addr, ram_data_in and ram_wr_mask are driven from the latched registers.
  - ram_wr = latched wr AND NOT rst.
  - ram_wr_mask is forced to 0 when the latched wr=0.
  - Go to RESP.
- RESP:
  - Assert the granted master's ack for exactly one cycle.
  - Its data output is passed through from ram_data_out.
  - ram_wr = 0. Go to IDLE.
- Outside ISSUE: ram_wr=0 and ram_wr_mask=0. ram_addr and ram_data_in hold the latched values.
- The non-granted master's ack is 0. Its data output is don't-care while its ack is low.
- A write with mask 4'b0000 still consumes a full slot and is acked; RAM contents are unchanged.
- A requester dropping req before ack is a protocol violation. The latched access still completes and acks.
- A request still high in the cycle after ack is treated as a new request.
- Reset values: state IDLE, last_grant=fetch, all latched registers 0.
  - Outputs: i_ack=0, d_ack=0, busy=0, ram_wr=0, ram_wr_mask=0, ram_addr=0, ram_data_in=0.
- Reset mid-operation: the next state is IDLE. No ack is issued for the aborted access. A write whose ISSUE cycle coincides with rst is suppressed.

## Timing

- A request sampled in IDLE at cycle T gives: ISSUE at T+1 (RAM samples at the end of T+1), then ack and data at T+2, then IDLE at T+3.
- Latency from req to ack is 2 cycles. Throughput is one access per 3 cycles.
- With both masters requesting continuously, grants alternate. Each master gets one access per 6 cycles and neither starves.
- i_data and d_rdata are combinational from ram_data_out. No extra register stage.

## Test plan

- Reset, then fetch-only read of addr 0x005 (RAM preloaded 0xDEADBEEF): i_ack at T+2 with i_data=0xDEADBEEF; ram_wr never high; busy high T+1..T+2.
- Data write to addr 0x010 with data 0x11223344, mask 4'b0101, old contents 0xAABBCCDD: ram_wr high only at T+1; d_rdata=0xAABBCCDD at ack; a subsequent read returns 0xAA22CC44.
- Simultaneous i_req and d_req held from reset: grants go D, I, D, I. Acks arrive at cycles 2, 5, 8, 11 after the first sample, alternating d_ack and i_ack.
- Write with mask 4'b0000 to addr 0x020: acked at T+2, and a later read shows unchanged contents.
- rst asserted during the ISSUE cycle of a data write: ram_wr stays 0, no d_ack, RAM word unchanged, and state is IDLE on the next cycle.
- d_req deasserted in the ISSUE cycle: d_ack still pulses at T+2, and no second access starts.
